// File: rtl/screen_layer_ctrl.sv
// screen_layer_ctrl
// Frame-synchronous game-phase sequencer. Chooses which display layers reach
// the RGB priority mux, blinks selected layers at a frame-counted rate and
// holds game logic (freeze) whenever the game is not in active play.
module screen_layer_ctrl #(
  parameter int INTRO_FRAMES = 60,
  parameter int BLINK_FRAMES = 15,
  parameter int DEATH_FRAMES = 120,
  parameter int DONE_FRAMES  = 90,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       restart,
  input  logic       player_dead,
  input  logic       level_complete,
  input  logic       game_over,
  output logic [9:0] layer_en,
  output logic       freeze,
  output logic [2:0] screen_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INTRO = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DEATH = 3'd3,
    ST_DONE  = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  // Last frame index of each timed phase: the exit happens on the pulse that
  // arrives while the counter already holds this value.
  localparam logic [7:0] INTRO_LAST = 8'(INTRO_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] DONE_LAST  = 8'(DONE_FRAMES - 1);
  localparam logic [7:0] HOLD_MIN   = 8'(HOLD_FRAMES);

  localparam logic [9:0] MASK_RESET = 10'h3C0;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] frame_cnt_r;
  logic [7:0] frame_cnt_nxt_s;
  logic [7:0] blink_cnt_r;
  logic [7:0] blink_cnt_nxt_s;
  logic       ph_r;
  logic       ph_nxt_s;
  logic [9:0] layer_en_r;
  logic       freeze_r;

  // Layer mask for a given phase and blink phase (ph=1 means visible).
  function automatic logic [9:0] mask_f(input state_t st, input logic ph);
    logic [9:0] m;
    case (st)
      ST_IDLE:  m = {ph, 3'b111, 6'b000000};
      ST_INTRO: m = 10'h1C0;
      ST_PLAY:  m = 10'h1FF;
      ST_DEATH: m = 10'h1EF | {5'b00000, ph, 4'b0000};
      ST_DONE:  m = 10'h1FD | {8'h00, ph, 1'b0};
      ST_OVER:  m = {ph, 9'h1FF};
      default:  m = MASK_RESET;
    endcase
    return m;
  endfunction

  // Next-phase decision; PLAY events are prioritised game_over > dead > done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (restart) state_nxt_s = ST_INTRO;
        else         state_nxt_s = state_r;
      end
      ST_INTRO: begin
        if (startOfFrame && (frame_cnt_r == INTRO_LAST)) state_nxt_s = ST_PLAY;
        else                                             state_nxt_s = state_r;
      end
      ST_PLAY: begin
        if (game_over)           state_nxt_s = ST_OVER;
        else if (player_dead)    state_nxt_s = ST_DEATH;
        else if (level_complete) state_nxt_s = ST_DONE;
        else                     state_nxt_s = state_r;
      end
      ST_DEATH: begin
        if (startOfFrame && (frame_cnt_r == DEATH_LAST)) state_nxt_s = ST_INTRO;
        else                                             state_nxt_s = state_r;
      end
      ST_DONE: begin
        if (startOfFrame && (frame_cnt_r == DONE_LAST)) state_nxt_s = ST_INTRO;
        else                                            state_nxt_s = state_r;
      end
      ST_OVER: begin
        if (restart && (frame_cnt_r >= HOLD_MIN)) state_nxt_s = ST_INTRO;
        else                                      state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Frame and blink counters; a phase change restarts them and a frame pulse
  // in the same cycle is not credited to the new phase.
  always_comb begin
    frame_cnt_nxt_s = frame_cnt_r;
    blink_cnt_nxt_s = blink_cnt_r;
    ph_nxt_s        = ph_r;
    if (state_nxt_s != state_r) begin
      frame_cnt_nxt_s = 8'd0;
      blink_cnt_nxt_s = 8'd0;
      ph_nxt_s        = 1'b1;
    end else if (startOfFrame) begin
      if (frame_cnt_r != 8'hFF) frame_cnt_nxt_s = frame_cnt_r + 8'd1;
      else                      frame_cnt_nxt_s = frame_cnt_r;
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_nxt_s = 8'd0;
        ph_nxt_s        = ~ph_r;
      end else begin
        blink_cnt_nxt_s = blink_cnt_r + 8'd1;
        ph_nxt_s        = ph_r;
      end
    end else begin
      frame_cnt_nxt_s = frame_cnt_r;
      blink_cnt_nxt_s = blink_cnt_r;
      ph_nxt_s        = ph_r;
    end
  end

  // State, counters and the registered output decode.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ST_IDLE;
      frame_cnt_r <= 8'd0;
      blink_cnt_r <= 8'd0;
      ph_r        <= 1'b1;
      layer_en_r  <= MASK_RESET;
      freeze_r    <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      blink_cnt_r <= blink_cnt_nxt_s;
      ph_r        <= ph_nxt_s;
      layer_en_r  <= mask_f(state_nxt_s, ph_nxt_s);
      freeze_r    <= (state_nxt_s != ST_PLAY);
    end
  end

  assign layer_en     = layer_en_r;
  assign freeze       = freeze_r;
  assign screen_state = state_r;

endmodule
